button_mem_writer: RTL and testbench
====================================

// Module: button_mem_writer
// PURPOSE
//  Operator-input initiator on the data-memory write port: debounces button_up/button_down, edits a
//  WIDTH-bit value (+STEP / -STEP) and, on an up+down chord, writes it to the MAX or MIN display slot.
//  Sits beside the CPU on the dmemory write port; a req/gnt handshake with the bus arbiter gives
//  exclusive use for exactly one write.
// PARAMETERS
//  WIDTH       32    data and address width
//  DEB_CYCLES  20    cycles a raw button level must be stable before the debounced level changes
//  STEP        1     increment/decrement amount (unsigned, modulo 2^WIDTH)
//  ADDR_MAX    0     word address of the MAX display slot (sel=0); matches MAX_NUM_ADDRESS in config.v
//  ADDR_MIN    1     word address of the MIN display slot (sel=1); matches MIN_NUM_ADDRESS in config.v
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  button_up      in   1      raw button, asynchronous to clk, 1 = pressed
//  button_down    in   1      raw button, asynchronous to clk, 1 = pressed
//  sel            in   1      target slot: 0 = ADDR_MAX, 1 = ADDR_MIN; sampled at commit
//  wr_req         out  1      write port request to arbiter
//  wr_gnt         in   1      arbiter grant; only meaningful while wr_req=1
//  mem_write      out  1      one-cycle write strobe to dmemory
//  write_address  out  WIDTH  write address, held stable while mem_write=1
//  write_data     out  WIDTH  write data, held stable while mem_write=1
//  edit_value     out  WIDTH  current edit value (for display)
//  write_done     out  1      one-cycle pulse the cycle after the write strobe
// BEHAVIOUR
//  - Reset (reset=0, async): edit_value=0; wr_req, mem_write, write_done = 0; write_address,
//    write_data = 0; FSM=IDLE; debounced levels=0; chord flag=0. Deassertion is synchronised inside.
//  - Debounce: per button, a 2-flop synchroniser and a counter. The debounced level takes the synced level
//    after DEB_CYCLES consecutive equal samples; any mismatch clears the counter. Latency from raw edge to
//    debounced edge: DEB_CYCLES+2 clk.
//  - Chord: both debounced levels =1 in the same cycle sets chord flag and raises commit (one cycle). The flag
//    clears only when both debounced levels are 0.
//  - Edit: a debounced falling edge of a single button with chord flag=0 applies the action:
//    up releases -> edit_value += STEP, down releases -> edit_value -= STEP.
//    Wraps modulo 2^WIDTH (0 - 1 = 2^WIDTH-1). Releases while chord flag=1 do nothing.
//    Edits occur only in IDLE; in other states they are dropped, not queued.
//  - FSM: IDLE -commit-> REQ: latch write_data=edit_value and write_address=(sel?ADDR_MIN:ADDR_MAX);
//    wr_req=1.
//    REQ -wr_gnt=1-> WRITE: wr_req stays 1.
//    WRITE (exactly 1 cycle): mem_write=1 and wr_req=1 -> DONE.
//    DONE (1 cycle): write_done=1, wr_req=0 -> IDLE.
//    REQ waits indefinitely for gnt; commit outside IDLE is ignored.
//  - Latency: commit cycle N -> wr_req at N+1; gnt seen at cycle M -> mem_write at M+1, write_done at M+2.
//    mem_read is never driven; the block never reads memory.
//  - Reset mid-transaction returns to IDLE with wr_req and mem_write low immediately (async).
//    A lost write is acceptable.
// STRUCTURE
//  - Shared constants: ADDR_MAX/ADDR_MIN defaults come from config.v (MAX_NUM_ADDRESS, MIN_NUM_ADDRESS).
//    FSM state encodings as localparams: IDLE=2'd0, REQ=2'd1, WRITE=2'd2, DONE=2'd3.
//  - One sub-module: button_debounce #(DEB_CYCLES) (clk, reset, raw, level); instantiated twice.
//  - Top holds the edge/chord logic, the edit register and the FSM.
// TESTING (bench uses DEB_CYCLES=4, STEP=1, ADDR_MAX=0, ADDR_MIN=1)
//  1 Reset: hold reset=0 with buttons toggling -> all outputs 0; after release edit_value=0, FSM IDLE.
//  2 Bounce: glitch up for 3 clk, then press 10 clk, then release -> exactly one increment, edit_value=1.
//    The debounced edge comes 6 clk after the stable level.
//  3 Wrap: from 0, one down press/release -> edit_value=32'hFFFF_FFFF.
//    Then one up press/release -> 0.
//  4 Commit: set edit_value=5, sel=1, chord; hold wr_gnt=0 for 7 clk, then 1.
//    -> wr_req high throughout; mem_write one cycle after gnt, with address 1 and data 5.
//    write_done on the next cycle. Chord releases do not change edit_value.
//  5 Busy: a second chord and an up release during REQ -> ignored; exactly one write, edit_value unchanged.
//  6 Abort: assert reset during WRITE -> mem_write/wr_req fall with no clk edge; no write_done pulse.

Source files
------------

// File: rtl/button_mem_writer_pkg.sv
// Shared constants and FSM encoding for the operator-driven data-memory writer.
package button_mem_writer_pkg;

  localparam int unsigned MAX_NUM_ADDRESS = 0;
  localparam int unsigned MIN_NUM_ADDRESS = 1;

  localparam int N_BUTTONS = 2;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/button_mem_writer_if.sv
// Arbitrated write-port bundle between the button writer (master) and dmemory/arbiter (slave).
interface button_mem_writer_if #(
  parameter int WIDTH = 32
);
  logic             wr_req;
  logic             wr_gnt;
  logic             mem_write;
  logic [WIDTH-1:0] write_address;
  logic [WIDTH-1:0] write_data;

  modport master (
    output wr_req, mem_write, write_address, write_data,
    input  wr_gnt
  );

  modport slave (
    input  wr_req, mem_write, write_address, write_data,
    output wr_gnt
  );
endinterface

// File: rtl/button_mem_writer_debounce.sv
// Two-flop synchroniser plus stability counter; the output follows the synced level only after
// DEB_CYCLES consecutive samples that disagree with the current output.
module button_debounce
  import button_mem_writer_pkg::*;
#(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw};
      // Any sample that agrees with the current output restarts the stability window.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
endmodule

// File: rtl/button_mem_writer.sv
// Debounced up/down editor of a WIDTH-bit value; an up+down chord writes it once to the
// MAX or MIN display slot through a req/gnt-arbitrated memory write port.
module button_mem_writer
  import button_mem_writer_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          DEB_CYCLES = 20,
  parameter int unsigned STEP       = 1,
  parameter int unsigned ADDR_MAX   = MAX_NUM_ADDRESS,
  parameter int unsigned ADDR_MIN   = MIN_NUM_ADDRESS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                button_up,
  input  logic                button_down,
  input  logic                sel,
  button_mem_writer_if.master bus,
  output logic [WIDTH-1:0]    edit_value,
  output logic                write_done
);
  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [N_BUTTONS-1:0]   w_raw;
  logic [N_BUTTONS-1:0]   w_level;
  logic [N_BUTTONS-1:0]   r_level_prev;
  logic [N_BUTTONS-1:0]   w_fall;
  logic                   r_chord;
  logic                   w_commit;
  logic                   w_inc;
  logic                   w_dec;
  logic [WIDTH-1:0]       r_edit_value;
  wr_state_e              r_state;
  logic                   r_wr_req;
  logic                   r_mem_write;
  logic                   r_write_done;
  logic [WIDTH-1:0]       r_write_address;
  logic [WIDTH-1:0]       r_write_data;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_raw[BTN_UP]   = button_up;
  assign w_raw[BTN_DOWN] = button_down;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_deb
      button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .reset (w_rst_n),
        .raw   (w_raw[gi]),
        .level (w_level[gi])
      );
    end
  endgenerate

  assign w_fall   = r_level_prev & ~w_level;
  assign w_commit = (&w_level) & ~r_chord;
  assign w_inc    = w_fall[BTN_UP] & ~w_fall[BTN_DOWN] & ~r_chord;
  assign w_dec    = w_fall[BTN_DOWN] & ~w_fall[BTN_UP] & ~r_chord;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_level_prev <= '0;
      r_chord      <= 1'b0;
      r_edit_value <= '0;
    end else begin
      r_level_prev <= w_level;
      if (&w_level) begin
        r_chord <= 1'b1;
      end else if (w_level == '0) begin
        r_chord <= 1'b0;
      end
      // Edits outside IDLE are dropped so the committed value cannot drift mid-write.
      if (r_state == ST_IDLE) begin
        if (w_inc) begin
          r_edit_value <= r_edit_value + WIDTH'(STEP);
        end else if (w_dec) begin
          r_edit_value <= r_edit_value - WIDTH'(STEP);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state         <= ST_IDLE;
      r_wr_req        <= 1'b0;
      r_mem_write     <= 1'b0;
      r_write_done    <= 1'b0;
      r_write_address <= '0;
      r_write_data    <= '0;
    end else begin
      r_write_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_commit) begin
            r_state         <= ST_REQ;
            r_wr_req        <= 1'b1;
            r_write_data    <= r_edit_value;
            r_write_address <= sel ? WIDTH'(ADDR_MIN) : WIDTH'(ADDR_MAX);
          end
        end
        ST_REQ: begin
          if (bus.wr_gnt) begin
            r_state     <= ST_WRITE;
            r_mem_write <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_state      <= ST_DONE;
          r_mem_write  <= 1'b0;
          r_wr_req     <= 1'b0;
          r_write_done <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_req        = r_wr_req;
  assign bus.mem_write     = r_mem_write;
  assign bus.write_address = r_write_address;
  assign bus.write_data    = r_write_data;
  assign edit_value        = r_edit_value;
  assign write_done        = r_write_done;
endmodule

// File: tb/tb_button_mem_writer.sv
// Directed bench for button_mem_writer: a transaction-level model (expected edit value and a
// queue of expected writes) checked every cycle, plus hand-computed latency and value checks.
module tb_button_mem_writer;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             button_up = 1'b0;
  logic             button_down = 1'b0;
  logic             sel = 1'b0;
  logic [WIDTH-1:0] edit_value;
  logic             write_done;

  button_mem_writer_if #(.WIDTH(WIDTH)) bus ();

  button_mem_writer #(
    .WIDTH(WIDTH), .DEB_CYCLES(4), .STEP(1), .ADDR_MAX(0), .ADDR_MIN(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_up   (button_up),
    .button_down (button_down),
    .sel         (sel),
    .bus         (bus),
    .edit_value  (edit_value),
    .write_done  (write_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  logic [31:0] model_edit = 0;
  bit          model_valid = 1'b1;
  wr_t         exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input logic up, input logic dn, input logic [31:0] delta);
    model_valid = 1'b0;
    button_up   = up;
    button_down = dn;
    tick(10);
    button_up   = 1'b0;
    button_down = 1'b0;
    tick(10);
    model_edit  = model_edit + delta;
    model_valid = 1'b1;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Per-cycle compare against the transaction model and the handshake rules.
  bit prev_mw = 1'b0;
  bit prev_req_gnt = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_wr_req", 32'(bus.wr_req), 0);
      check("rst_mem_write", 32'(bus.mem_write), 0);
      check("rst_write_done", 32'(write_done), 0);
      check("rst_edit_value", edit_value, 0);
      check("rst_write_address", bus.write_address, 0);
      check("rst_write_data", bus.write_data, 0);
      prev_mw      = 1'b0;
      prev_req_gnt = 1'b0;
    end else begin
      check("cyc_mem_write", 32'(bus.mem_write), 32'(prev_req_gnt));
      check("cyc_write_done", 32'(write_done), 32'(prev_mw));
      if (model_valid) check("cyc_edit_value", edit_value, model_edit);
      if (bus.mem_write) begin
        n_writes++;
        check("cyc_req_during_write", 32'(bus.wr_req), 1);
        $display("write addr=%0h data=%0h at %0t", bus.write_address, bus.write_data, $time);
        if (exp_q.size() == 0) begin
          check("cyc_unexpected_write", 1, 0);
        end else begin
          check("cyc_write_address", bus.write_address, exp_q[0].addr);
          check("cyc_write_data", bus.write_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
      prev_mw      = bus.mem_write;
      prev_req_gnt = bus.wr_req & ~bus.mem_write & bus.wr_gnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_gnt = 1'b0;
    #2 reset = 1'b0;

    // 1 Reset with toggling buttons
    for (int i = 0; i < 8; i++) begin
      tick(1);
      button_up   = i[0];
      button_down = i[1];
    end
    check("t1_edit_in_reset", edit_value, 0);
    check("t1_req_in_reset", 32'(bus.wr_req), 0);
    button_up   = 1'b0;
    button_down = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(12);
    check("t1_edit_after_reset", edit_value, 0);
    check("t1_idle_after_reset", 32'(bus.wr_req), 0);

    // 2 Bounce: a 3-cycle glitch is rejected, a real press gives one increment
    model_valid = 1'b0;
    button_up = 1'b1;
    tick(3);
    button_up = 1'b0;
    tick(10);
    check("t2_glitch_ignored", edit_value, 0);
    button_up = 1'b1;
    tick(10);
    button_up = 1'b0;
    tick(6);
    check("t2_edit_before_edge", edit_value, 0);
    tick(1);
    check("t2_edit_after_edge", edit_value, 1);
    tick(5);
    model_edit  = 1;
    model_valid = 1'b1;
    check("t2_edit_final", edit_value, 32'd1);

    // 3 Wrap: back to 0, then down wraps to all-ones, up returns to 0
    press_release(1'b0, 1'b1, 32'hFFFF_FFFF);
    check("t3_back_to_zero", edit_value, 0);
    press_release(1'b0, 1'b1, 32'hFFFF_FFFF);
    check("t3_wrap_down", edit_value, 32'hFFFF_FFFF);
    press_release(1'b1, 1'b0, 32'd1);
    check("t3_wrap_up", edit_value, 0);

    // 4 Commit with delayed grant
    for (int i = 0; i < 5; i++) press_release(1'b1, 1'b0, 32'd1);
    check("t4_edit_five", edit_value, 5);
    sel = 1'b1;
    button_up   = 1'b1;
    button_down = 1'b1;
    tick(6);
    check("t4_req_before_commit", 32'(bus.wr_req), 0);
    tick(1);
    check("t4_req_after_commit", 32'(bus.wr_req), 1);
    expect_write(32'd1, 32'd5);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("t4_req_waiting", 32'(bus.wr_req), 1);
      check("t4_no_write_waiting", 32'(bus.mem_write), 0);
    end
    bus.wr_gnt = 1'b1;
    tick(1);
    bus.wr_gnt = 1'b0;
    check("t4_mem_write", 32'(bus.mem_write), 1);
    check("t4_address", bus.write_address, 1);
    check("t4_data", bus.write_data, 5);
    check("t4_req_in_write", 32'(bus.wr_req), 1);
    tick(1);
    check("t4_mem_write_end", 32'(bus.mem_write), 0);
    check("t4_write_done", 32'(write_done), 1);
    check("t4_req_dropped", 32'(bus.wr_req), 0);
    tick(1);
    check("t4_write_done_end", 32'(write_done), 0);
    button_up   = 1'b0;
    button_down = 1'b0;
    tick(15);
    check("t4_chord_release_no_edit", edit_value, 5);

    // 5 Busy: second chord and an up release while waiting for grant are ignored
    sel = 1'b0;
    button_up   = 1'b1;
    button_down = 1'b1;
    tick(7);
    check("t5_req", 32'(bus.wr_req), 1);
    expect_write(32'd0, 32'd5);
    button_up   = 1'b0;
    button_down = 1'b0;
    tick(12);
    press_release(1'b1, 1'b0, 32'd0);
    press_release(1'b1, 1'b1, 32'd0);
    check("t5_still_req", 32'(bus.wr_req), 1);
    check("t5_edit_unchanged", edit_value, 5);
    bus.wr_gnt = 1'b1;
    tick(1);
    bus.wr_gnt = 1'b0;
    check("t5_mem_write", 32'(bus.mem_write), 1);
    check("t5_address", bus.write_address, 0);
    tick(1);
    check("t5_write_done", 32'(write_done), 1);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      check("t5_no_second_req", 32'(bus.wr_req), 0);
    end

    // 6 Abort: reset during WRITE drops outputs without a clock edge
    sel = 1'b1;
    button_up   = 1'b1;
    button_down = 1'b1;
    tick(7);
    check("t6_req", 32'(bus.wr_req), 1);
    expect_write(32'd1, 32'd5);
    bus.wr_gnt = 1'b1;
    tick(1);
    bus.wr_gnt = 1'b0;
    check("t6_mem_write", 32'(bus.mem_write), 1);
    @(negedge clk);
    #1;
    reset       = 1'b0;
    button_up   = 1'b0;
    button_down = 1'b0;
    model_edit  = 0;
    #1;
    check("t6_abort_mem_write", 32'(bus.mem_write), 0);
    check("t6_abort_wr_req", 32'(bus.wr_req), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick(12);
    check("t6_edit_after_abort", edit_value, 0);
    check("t6_idle_after_abort", 32'(bus.wr_req), 0);

    check("end_write_count", 32'(n_writes), 3);
    check("end_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
